load_store_unit: RTL

- Initiator side of the core data bus.
- Accepts one load/store request at a time from the execute stage and computes the effective address.
- Drives the bus signals rw/len/addr/write, samples read/exception, then returns sign- or zero-extended load data, or a fault cause, to writeback through a valid/ready handshake.
- One request in flight; sits between the execute stage and the data bus.

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: data-bus initiator that computes ea = base + sext(offset), runs one bus access and returns extended load data or a fault.
// Latency: 2 cycles from acceptance to resp_valid for an aligned access; 1 for a misaligned fault; 1 + beats when split.
// Backpressure: one request in flight; req_ready only in IDLE; the response is held stable until resp_ready.
//
// Build option: define MISALIGNED_SPLIT_EN to break misaligned H/W accesses into byte beats instead of faulting.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_*               - request from execute (valid/ready), funct3 width/sign code, base, offset, store data, rd tag
//   resp_*              - response to writeback (valid/ready), extended data, rd tag, exception flag + cause
//   bus_rw/len/addr/write - bus command, driven only during ACCESS, zero otherwise
//   bus_read, bus_exception - combinational bus return for the current address
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [IMM_W-1:0]  req_offset,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_exception,
  output logic [3:0]        resp_cause,
  output logic              bus_rw,
  output logic [1:0]        bus_len,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_write,
  input  logic [31:0]       bus_read,
  input  logic              bus_exception
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [ADDR_W-1:0] ea_q;
  logic [1:0]        len_q;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;

  // Byte-beat bookkeeping (only ever active in the split build)
  logic              split_q;
  logic [1:0]        beat_q;
  logic [31:0]       rbuf_q;

  // Response registers
  logic [31:0]       data_q;
  logic              exc_q;
  logic [3:0]        cause_q;

  logic [ADDR_W-1:0] ea;
  logic [1:0]        req_len;
  logic              misaligned;
  logic              split_ok;
  logic              accept;
  logic              last_beat;
  logic [31:0]       raw_word;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b100:  extend = {24'h0, w[7:0]};
      3'b101:  extend = {16'h0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  assign ea      = req_base + {{(ADDR_W-IMM_W){req_offset[IMM_W-1]}}, req_offset};
  assign req_len = req_funct3[1:0];

  // len 3 is not a legal width; folding it into "misaligned" makes it fault.
  assign misaligned = ((req_len == 2'd1) && ea[0]) ||
                      ((req_len == 2'd2) && (ea[1:0] != 2'b00)) ||
                      (req_len == 2'd3);

`ifdef MISALIGNED_SPLIT_EN
  assign split_ok = misaligned && (req_len != 2'd3);
`else
  assign split_ok = 1'b0;
`endif

  assign accept = req_valid && (state_q == IDLE);

  // H needs beats 0..1, W needs 0..3.
  assign last_beat = !split_q || (beat_q == ((len_q == 2'd1) ? 2'd1 : 2'd3));

  // Split loads accumulate little-endian; the final beat's byte is merged combinationally.
  always_comb begin
    raw_word = bus_read;
    if (split_q) begin
      raw_word = rbuf_q;
      raw_word[{beat_q, 3'b000} +: 8] = bus_read[7:0];
    end
  end

  // Bus is fully quiet outside ACCESS so no stray writes can reach IO.
  always_comb begin
    bus_rw    = 1'b0;
    bus_len   = 2'd0;
    bus_addr  = '0;
    bus_write = '0;
    if (state_q == ACCESS) begin
      bus_rw = store_q;
      if (split_q) begin
        bus_len   = 2'd0;
        bus_addr  = ea_q + ADDR_W'(beat_q);
        bus_write = {24'h0, wdata_q[{beat_q, 3'b000} +: 8]};
      end else begin
        bus_len   = len_q;
        bus_addr  = ea_q;
        bus_write = wdata_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (misaligned && !split_ok) ? RESP : ACCESS;
      ACCESS:  if (bus_exception || last_beat) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ea_q     <= '0;
      len_q    <= 2'd0;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      wdata_q  <= 32'h0;
      rd_q     <= 5'd0;
      split_q  <= 1'b0;
      beat_q   <= 2'd0;
      rbuf_q   <= 32'h0;
      data_q   <= 32'h0;
      exc_q    <= 1'b0;
      cause_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            ea_q     <= ea;
            len_q    <= req_len;
            store_q  <= req_store;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            rd_q     <= req_rd;
            split_q  <= split_ok;
            beat_q   <= 2'd0;
            rbuf_q   <= 32'h0;
            data_q   <= 32'h0;
            exc_q    <= misaligned && !split_ok;
            cause_q  <= (misaligned && !split_ok) ? (req_store ? 4'd6 : 4'd4) : 4'd0;
          end
        end
        ACCESS: begin
          if (bus_exception) begin
            // Earlier split store bytes stay written; only the response reports the fault.
            exc_q   <= 1'b1;
            cause_q <= store_q ? 4'd7 : 4'd5;
            data_q  <= 32'h0;
          end else if (last_beat) begin
            exc_q   <= 1'b0;
            cause_q <= 4'd0;
            data_q  <= store_q ? 32'h0 : extend(funct3_q, raw_word);
          end else begin
            beat_q <= beat_q + 2'd1;
            rbuf_q <= raw_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign resp_data      = data_q;
  assign resp_rd        = rd_q;
  assign resp_exception = exc_q;
  assign resp_cause     = cause_q;

endmodule
